// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: exception codes, CP0
// register addresses, FSM state encoding and the MEM-stage exception flag layout.
package exc_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INT_W  = 6;
    localparam int unsigned RADR_W = 5;

    // CP0 register addresses that can be forwarded from the WB-stage write
    localparam logic [RADR_W-1:0] CP0_STATUS = 5'd12;
    localparam logic [RADR_W-1:0] CP0_CAUSE  = 5'd13;
    localparam logic [RADR_W-1:0] CP0_EPC    = 5'd14;

    // Exception codes reported to CP0 (0 = no exception)
    localparam logic [XLEN-1:0] EXC_NONE = 32'h0;
    localparam logic [XLEN-1:0] EXC_INT  = 32'h1;
    localparam logic [XLEN-1:0] EXC_ADEL = 32'h4;
    localparam logic [XLEN-1:0] EXC_ADES = 32'h5;
    localparam logic [XLEN-1:0] EXC_SYS  = 32'h8;
    localparam logic [XLEN-1:0] EXC_BP   = 32'h9;
    localparam logic [XLEN-1:0] EXC_RI   = 32'ha;
    localparam logic [XLEN-1:0] EXC_OV   = 32'hc;
    localparam logic [XLEN-1:0] EXC_TR   = 32'hd;
    localparam logic [XLEN-1:0] EXC_ERET = 32'he;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } exc_state_t;

    // First member is the MSB, so adel_if lands on bit 0
    typedef struct packed {
        logic eret;
        logic ades;
        logic adel_ld;
        logic brk;
        logic sys;
        logic trap;
        logic ov;
        logic ri;
        logic adel_if;
    } exc_flags_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-stage / CP0 bundle of the exception controller.
// master: pipeline + CP0 side (drives instruction state, CP0 values, WB write)
// slave : exception controller (drives exception context, flush and redirect)
interface exc_ctrl_if;
    import exc_ctrl_pkg::*;

    logic [INT_W-1:0]  int_i;
    logic [INT_W-1:0]  int_sync_o;
    logic              mem_valid_i;
    logic [XLEN-1:0]   mem_pc_i;
    logic              mem_in_delayslot_i;
    logic [XLEN-1:0]   mem_addr_i;
    exc_flags_t        exc_flags_i;
    logic [XLEN-1:0]   cp0_status_i;
    logic [XLEN-1:0]   cp0_cause_i;
    logic [XLEN-1:0]   cp0_epc_i;
    logic              wb_cp0_we_i;
    logic [RADR_W-1:0] wb_cp0_waddr_i;
    logic [XLEN-1:0]   wb_cp0_data_i;
    logic [XLEN-1:0]   excepttype_o;
    logic [XLEN-1:0]   current_inst_addr_o;
    logic              is_in_delayslot_o;
    logic [XLEN-1:0]   bad_addr_o;
    logic              flush_o;
    logic [XLEN-1:0]   new_pc_o;

    modport master (
        output int_i, mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_addr_i,
               exc_flags_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        input  int_sync_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o,
               bad_addr_o, flush_o, new_pc_o
    );

    modport slave (
        input  int_i, mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_addr_i,
               exc_flags_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        output int_sync_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o,
               bad_addr_o, flush_o, new_pc_o
    );

endinterface

// File: rtl/exc_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// Ports: clk, rst (sync, active-high, clears both stages), d (async in), q (synced out).
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: prioritises the MEM-stage exception/interrupt, reports
// it to CP0, then issues a one-cycle flush with redirect PC and ignores further
// exceptions for DRAIN_CYCLES cycles.
// Ports: clk, rst (sync, active-high); bus (exc_ctrl_if.slave) carries interrupt
// lines, MEM-stage instruction state, CP0 values, WB CP0 write, and the
// exception context / flush / new_pc outputs.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst,
    exc_ctrl_if.slave    bus
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    exc_state_t          state;
    logic [CNT_W-1:0]    drain_cnt;
    logic                flush_r;
    logic [XLEN-1:0]     new_pc_r;
    logic [INT_W-1:0]    int_sync;

    logic                wr_status, wr_cause, wr_epc;
    logic [7:0]          eff_im, eff_ip;
    logic                eff_ie, eff_exl;
    logic [XLEN-1:0]     eff_epc;
    logic                int_pending;
    logic [XLEN-1:0]     win_code;
    logic                win_adel_if;
    logic [XLEN-1:0]     exc_code;

    sync2 #(.WIDTH(INT_W)) u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (bus.int_i),
        .q   (int_sync)
    );

    // Forward an in-flight WB write so a same-cycle mtc0 is honoured
    always_comb begin
        wr_status = bus.wb_cp0_we_i && (bus.wb_cp0_waddr_i == CP0_STATUS);
        wr_cause  = bus.wb_cp0_we_i && (bus.wb_cp0_waddr_i == CP0_CAUSE);
        wr_epc    = bus.wb_cp0_we_i && (bus.wb_cp0_waddr_i == CP0_EPC);
        eff_im    = wr_status ? bus.wb_cp0_data_i[15:8] : bus.cp0_status_i[15:8];
        eff_ie    = wr_status ? bus.wb_cp0_data_i[0]    : bus.cp0_status_i[0];
        eff_exl   = wr_status ? bus.wb_cp0_data_i[1]    : bus.cp0_status_i[1];
        eff_ip    = {bus.cp0_cause_i[15:10],
                     wr_cause ? bus.wb_cp0_data_i[9:8] : bus.cp0_cause_i[9:8]};
        eff_epc   = wr_epc ? bus.wb_cp0_data_i : bus.cp0_epc_i;
        int_pending = ((eff_ip & eff_im) != 8'h00) && eff_ie && !eff_exl;
    end

    // Fixed-priority winner, interrupt first
    always_comb begin
        win_code    = EXC_NONE;
        win_adel_if = 1'b0;
        if (int_pending)                   win_code = EXC_INT;
        else if (bus.exc_flags_i.adel_if) begin
            win_code    = EXC_ADEL;
            win_adel_if = 1'b1;
        end
        else if (bus.exc_flags_i.ri)      win_code = EXC_RI;
        else if (bus.exc_flags_i.ov)      win_code = EXC_OV;
        else if (bus.exc_flags_i.trap)    win_code = EXC_TR;
        else if (bus.exc_flags_i.sys)     win_code = EXC_SYS;
        else if (bus.exc_flags_i.brk)     win_code = EXC_BP;
        else if (bus.exc_flags_i.adel_ld) win_code = EXC_ADEL;
        else if (bus.exc_flags_i.ades)    win_code = EXC_ADES;
        else if (bus.exc_flags_i.eret)    win_code = EXC_ERET;
    end

    assign exc_code = (!rst && (state == ST_IDLE) && bus.mem_valid_i) ? win_code : EXC_NONE;

    // IDLE -> FLUSH (one cycle) -> DRAIN (DRAIN_CYCLES cycles) -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            flush_r   <= 1'b0;
            new_pc_r  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (exc_code != EXC_NONE) begin
                        state    <= ST_FLUSH;
                        flush_r  <= 1'b1;
                        new_pc_r <= (exc_code == EXC_ERET) ? eff_epc : EXC_VECTOR;
                    end
                end
                ST_FLUSH: begin
                    state     <= ST_DRAIN;
                    flush_r   <= 1'b0;
                    drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) state <= ST_IDLE;
                    else                 drain_cnt <= drain_cnt - CNT_W'(1);
                end
                default: begin
                    state   <= ST_IDLE;
                    flush_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_sync_o          = int_sync;
    assign bus.excepttype_o        = exc_code;
    assign bus.current_inst_addr_o = bus.mem_pc_i;
    assign bus.is_in_delayslot_o   = bus.mem_in_delayslot_i;
    assign bus.bad_addr_o          = win_adel_if ? bus.mem_pc_i : bus.mem_addr_i;
    assign bus.flush_o             = flush_r;
    assign bus.new_pc_o            = new_pc_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Testbench for exc_ctrl: directed scenarios plus randomized traffic, checked
// against a cycle-level behavioural model through an expectation queue.
module tb_exc_ctrl;

    localparam int unsigned D   = 3;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exc_ctrl_if bus();

    exc_ctrl #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] exc;
        logic [31:0] bad;
        logic [31:0] pc;
        logic        ds;
        logic        flush;
        logic [31:0] npc;
        logic [5:0]  isync;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // stimulus for the next cycle
    logic        s_rst, s_valid, s_ds, s_we;
    logic [5:0]  s_int;
    logic [31:0] s_pc, s_addr, s_status, s_cause, s_epc, s_wdata;
    logic [8:0]  s_flags;
    logic [4:0]  s_waddr;

    // model state: registers as they stand after the latest clock edge
    int          busy;        // cycles left before new exceptions are taken
    logic        m_flush;
    logic [31:0] m_npc;
    logic [5:0]  m_s1, m_s2;
    logic        p_rst;
    logic [31:0] p_exc, p_target;
    logic [5:0]  p_int;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    // Spec priority list; flag bit order {eret,ades,adel_ld,brk,sys,trap,ov,ri,adel_if}
    function automatic logic [31:0] ref_code(input logic ip, input logic [8:0] f);
        if (ip)   return 32'h1;
        if (f[0]) return 32'h4;
        if (f[1]) return 32'ha;
        if (f[2]) return 32'hc;
        if (f[3]) return 32'hd;
        if (f[4]) return 32'h8;
        if (f[5]) return 32'h9;
        if (f[6]) return 32'h4;
        if (f[7]) return 32'h5;
        if (f[8]) return 32'he;
        return 32'h0;
    endfunction

    task automatic quiet();
        s_rst = 1'b0; s_valid = 1'b0; s_ds = 1'b0; s_we = 1'b0; s_int = '0;
        s_pc = 32'h8000_0000; s_addr = '0; s_status = '0; s_cause = '0;
        s_epc = '0; s_wdata = '0; s_flags = '0; s_waddr = '0;
    endtask

    // Advance one cycle: update the model for the edge, drive s_*, push expectation
    task automatic step();
        logic [31:0] st, cs, epc, code, exc, bad, target;
        logic        ip;
        @(posedge clk);
        if (p_rst) begin
            busy = 0; m_flush = 1'b0; m_npc = '0; m_s1 = '0; m_s2 = '0;
        end else begin
            m_s2 = m_s1;
            m_s1 = p_int;
            if (p_exc != 0) begin
                busy = 1 + D; m_flush = 1'b1; m_npc = p_target;
            end else begin
                m_flush = 1'b0;
                if (busy > 0) busy--;
            end
        end
        #1;
        rst                     = s_rst;
        bus.int_i               = s_int;
        bus.mem_valid_i         = s_valid;
        bus.mem_pc_i            = s_pc;
        bus.mem_in_delayslot_i  = s_ds;
        bus.mem_addr_i          = s_addr;
        bus.exc_flags_i         = s_flags;
        bus.cp0_status_i        = s_status;
        // CP0 presents the synchronized lines in cause[15:10]
        bus.cp0_cause_i         = {s_cause[31:16], m_s2, s_cause[9:0]};
        bus.cp0_epc_i           = s_epc;
        bus.wb_cp0_we_i         = s_we;
        bus.wb_cp0_waddr_i      = s_waddr;
        bus.wb_cp0_data_i       = s_wdata;

        st  = (s_we && s_waddr == 5'd12) ? s_wdata : s_status;
        cs  = {s_cause[31:16], m_s2, s_cause[9:0]};
        if (s_we && s_waddr == 5'd13) cs[9:8] = s_wdata[9:8];
        epc = (s_we && s_waddr == 5'd14) ? s_wdata : s_epc;
        ip  = ((cs[15:8] & st[15:8]) != 0) && st[0] && !st[1];
        code   = ref_code(ip, s_flags);
        exc    = (s_rst || busy != 0 || !s_valid) ? 32'h0 : code;
        bad    = (!ip && s_flags[0]) ? s_pc : s_addr;
        target = (code == 32'he) ? epc : VEC;
        exp_q.push_back('{exc: exc, bad: bad, pc: s_pc, ds: s_ds, flush: m_flush,
                          npc: m_npc, isync: m_s2});
        p_rst = s_rst; p_exc = exc; p_target = target; p_int = s_int;
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("excepttype", bus.excepttype_o, e.exc);
            chk("flush", 32'(bus.flush_o), 32'(e.flush));
            chk("int_sync", 32'(bus.int_sync_o), 32'(e.isync));
            chk("inst_addr", bus.current_inst_addr_o, e.pc);
            chk("delayslot", 32'(bus.is_in_delayslot_o), 32'(e.ds));
            if (e.exc != 0) chk("bad_addr", bus.bad_addr_o, e.bad);
            if (e.flush)    chk("new_pc", bus.new_pc_o, e.npc);
        end
    end

    task automatic settle(input int n);
        quiet();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int exp_code[6];
        int exp_fl[6];
        quiet();
        rst = 1'b1;
        bus.int_i = '0; bus.mem_valid_i = 1'b0; bus.mem_pc_i = '0;
        bus.mem_in_delayslot_i = 1'b0; bus.mem_addr_i = '0; bus.exc_flags_i = '0;
        bus.cp0_status_i = '0; bus.cp0_cause_i = '0; bus.cp0_epc_i = '0;
        bus.wb_cp0_we_i = 1'b0; bus.wb_cp0_waddr_i = '0; bus.wb_cp0_data_i = '0;
        p_rst = 1'b1; p_exc = '0; p_target = '0; p_int = '0;
        busy = 0; m_flush = 1'b0; m_npc = '0; m_s1 = '0; m_s2 = '0;

        // reset: outputs cleared, exception masked while rst=1
        s_rst = 1'b1; s_valid = 1'b1; s_flags = 9'h004;
        step(); step();
        #1;
        chk("rst_exc", bus.excepttype_o, 32'h0);
        chk("rst_flush", 32'(bus.flush_o), 32'h0);
        chk("rst_newpc", bus.new_pc_o, 32'h0);
        settle(2);

        // ov held continuously: taken, then ignored for flush + 3 drain cycles
        exp_code = '{32'hc, 0, 0, 0, 0, 32'hc};
        exp_fl   = '{0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            quiet(); s_valid = 1'b1; s_pc = 32'h8000_1000; s_flags = 9'h004;
            step(); #1;
            chk("ov_seq_exc", bus.excepttype_o, 32'(exp_code[i]));
            chk("ov_seq_flush", 32'(bus.flush_o), 32'(exp_fl[i]));
        end
        quiet(); step(); #1;
        chk("ov_flush", 32'(bus.flush_o), 32'h1);
        chk("ov_newpc", bus.new_pc_o, 32'hBFC00380);
        settle(5);

        // eret with forwarded EPC write
        quiet(); s_valid = 1'b1; s_flags = 9'h100; s_epc = 32'h8000_0000;
        s_we = 1'b1; s_waddr = 5'd14; s_wdata = 32'h8000_0040;
        step(); #1;
        chk("eret_exc", bus.excepttype_o, 32'he);
        quiet(); step(); #1;
        chk("eret_newpc", bus.new_pc_o, 32'h8000_0040);
        settle(5);

        // hardware interrupt visible exactly two cycles after int_i rises
        quiet(); s_valid = 1'b1; s_status = 32'h0000_FF01; s_int = 6'h01;
        step(); #1; chk("int_lat0", bus.excepttype_o, 32'h0);
        step(); #1; chk("int_lat1", bus.excepttype_o, 32'h0);
        s_flags = 9'h010;
        step(); #1;
        chk("int_exc", bus.excepttype_o, 32'h1);
        chk("int_sync", 32'(bus.int_sync_o), 32'h01);
        quiet(); s_int = 6'h01; step();
        // same-cycle status write clearing IE suppresses the interrupt
        settle(3);
        quiet(); s_int = 6'h01; s_valid = 1'b1; s_status = 32'h0000_FF01;
        s_flags = 9'h004; s_we = 1'b1; s_waddr = 5'd12; s_wdata = 32'h0000_FF00;
        step(); #1;
        chk("int_masked", bus.excepttype_o, 32'hc);
        settle(6);

        // adel_if beats adel_ld, bad address is the PC
        quiet(); s_valid = 1'b1; s_flags = 9'h041; s_pc = 32'h8000_0002; s_addr = 32'h1235;
        step(); #1;
        chk("adel_exc", bus.excepttype_o, 32'h4);
        chk("adel_bad", bus.bad_addr_o, 32'h8000_0002);
        settle(5);

        // reset during drain, exception right after is taken
        quiet(); s_valid = 1'b1; s_flags = 9'h004; step();
        settle(2);
        quiet(); s_rst = 1'b1; step();
        quiet(); s_valid = 1'b1; s_flags = 9'h004; step(); #1;
        chk("rst_drain_flush", 32'(bus.flush_o), 32'h0);
        chk("rst_drain_exc", bus.excepttype_o, 32'hc);
        quiet(); step(); #1;
        chk("rst_drain_take", 32'(bus.flush_o), 32'h1);
        settle(5);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            s_rst    = ($urandom_range(0, 49) == 0);
            s_valid  = ($urandom_range(0, 3) != 0);
            s_ds     = 1'($urandom);
            s_pc     = $urandom;
            s_addr   = $urandom;
            s_flags  = 9'($urandom) & 9'($urandom) & 9'($urandom);
            s_int    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : s_int;
            s_status = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
            s_cause  = {16'h0, 6'h0, 2'($urandom & $urandom), 8'h0};
            s_epc    = $urandom;
            s_we     = 1'($urandom);
            s_waddr  = 5'(12 + $urandom_range(0, 3));
            s_wdata  = $urandom;
            step();
        end
        settle(6);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
